apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 47 ++++
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Bundle of command, response and APB bus signals for the APB master.
// The master modport is the view used by apb_master. The slave modport is
// the view of whatever sits on the other side: the command source, the
// response sink and the APB completer.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master.
// It turns one command into one APB transfer and one response. A transfer is
// aborted after TIMEOUT consecutive ACCESS cycles with PREADY low. Every APB
// output and every rsp output comes straight from a flop.
module apb_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // Value the wait counter holds on the last wait cycle that is still allowed.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.PSELx       = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // Next-state and next-output logic; every register holds its value unless a state changes it.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    wait_d    = 8'd0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready completer takes priority over an expiring wait count.
                if (bus.PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any transfer in flight without a response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            wait_q        <= 8'd0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed corner cases followed by random transfers.
// A transaction-level model predicts every outcome. The model works from the
// number of PREADY-low cycles, the bus fields, the response timing and the
// response contents.
module tb_apb_master;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    apb_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

    apb_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .TIMEOUT(TMO)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic noise_slave();
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = 16'($urandom);
        bus.PSLVERR = 1'($urandom);
    endtask

    task automatic noise_cmd();
        bus.cmd_valid = 1'($urandom);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 4'($urandom);
        bus.cmd_wdata = 16'($urandom);
    endtask

    // Run one transfer, starting at a falling edge while the master is idle.
    // nwait is the number of ACCESS cycles with PREADY low before PREADY goes
    // high. bp is the number of RESP cycles with rsp_ready held low.
    task automatic xfer(input bit wr, input logic [3:0] addr, input logic [15:0] wd,
                        input int nwait, input logic [15:0] prd, input bit serr, input int bp);
        bit          to;
        int          acc;
        int          r;
        logic [15:0] erd;
        bit          eerr;
        to   = (nwait >= TMO);
        acc  = to ? TMO : nwait + 1;
        r    = 2 + acc;
        erd  = (to || wr) ? 16'h0 : prd;
        eerr = to || serr;

        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        noise_slave();
        bus.rsp_ready = 1'($urandom);

        for (int k = 1; k <= r; k++) begin
            @(negedge clk);
            noise_cmd();
            if (k < r) begin
                chk("psel", 32'(bus.PSELx), 32'd1);
                chk("penable", 32'(bus.PENABLE), 32'(k >= 2));
                chk("paddr", 32'(bus.PADDR), 32'(addr));
                chk("pwrite", 32'(bus.PWRITE), 32'(wr));
                chk("pwdata", 32'(bus.PWDATA), 32'(wd));
                chk("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
                chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
            end else begin
                chk("psel_done", 32'(bus.PSELx), 32'd0);
                chk("penable_done", 32'(bus.PENABLE), 32'd0);
                chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(erd));
                chk("rsp_err", 32'(bus.rsp_err), 32'(eerr));
                chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(to));
                chk("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
            end
            if (k >= 2 && k < r) begin
                bus.PREADY = !to && (k - 2 == nwait);
                if (bus.PREADY) begin
                    bus.PRDATA  = prd;
                    bus.PSLVERR = serr;
                end else begin
                    bus.PRDATA  = 16'($urandom);
                    bus.PSLVERR = 1'($urandom);
                end
            end else begin
                noise_slave();
            end
            bus.rsp_ready = (k < r) ? 1'($urandom) : (bp == 0);
        end

        for (int b = 1; b <= bp; b++) begin
            @(negedge clk);
            noise_cmd();
            noise_slave();
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(bus.rsp_rdata), 32'(erd));
            chk("bp_rsp_err", 32'(bus.rsp_err), 32'(eerr));
            chk("bp_rsp_timeout", 32'(bus.rsp_timeout), 32'(to));
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            bus.rsp_ready = (b == bp);
        end

        @(negedge clk);
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_psel", 32'(bus.PSELx), 32'd0);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'hF;
        bus.cmd_wdata = 16'hFFFF;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = 16'hFFFF;
        bus.PSLVERR   = 1'b1;

        // Reset state, with a command offered while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_psel", 32'(bus.PSELx), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_paddr", 32'(bus.PADDR), 32'd0);
        chk("rst_pwdata", 32'(bus.PWDATA), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_psel", 32'(bus.PSELx), 32'd0);

        // Directed scenarios.
        xfer(1'b1, 4'h4, 16'h0035, 0,  16'hAAAA, 1'b0, 0);  // write, zero wait
        xfer(1'b0, 4'h8, 16'h1234, 3,  16'h0011, 1'b0, 0);  // read, 3 wait cycles
        xfer(1'b0, 4'h0, 16'h0000, 0,  16'h5A5A, 1'b1, 0);  // slave error
        xfer(1'b0, 4'h3, 16'h0000, TMO, 16'h7777, 1'b0, 0); // timeout on read
        xfer(1'b1, 4'hC, 16'h9999, 40, 16'h7777, 1'b0, 1);  // timeout on write
        xfer(1'b0, 4'h5, 16'h0000, TMO - 1, 16'hBEEF, 1'b0, 0); // ready on last allowed cycle
        xfer(1'b0, 4'h6, 16'h0000, 1,  16'hC0DE, 1'b0, 5);  // response backpressure

        // Reset while in ACCESS abandons the transfer.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'h9;
        bus.cmd_wdata = 16'h4321;
        bus.PREADY    = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstacc_penable_before", 32'(bus.PENABLE), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstacc_psel", 32'(bus.PSELx), 32'd0);
        chk("rstacc_penable", 32'(bus.PENABLE), 32'd0);
        chk("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstacc_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rstacc_paddr", 32'(bus.PADDR), 32'd0);
        rst = 1'b0;
        bus.PREADY = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rstacc_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rstacc_idle_psel", 32'(bus.PSELx), 32'd0);
        bus.rsp_ready = 1'b0;

        // Random transfers.
        for (int i = 0; i < 25; i++) begin
            xfer(1'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 20)),
                 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
